// File: rtl/uart_echo_fifo_if.sv
// Receive-side word stream and transmit-side valid/ready stream of the UART echo buffer.
// master = surrounding logic (UART RX + TX), slave = the buffer itself.
interface uart_echo_fifo_if #(
  parameter int W_OUT = 16
);
  logic             rx_valid;
  logic [W_OUT-1:0] rx_data;
  logic             tx_ready;
  logic             tx_valid;
  logic [W_OUT-1:0] tx_data;

  modport master (
    output rx_valid, rx_data, tx_ready,
    input  tx_valid, tx_data
  );

  modport slave (
    input  rx_valid, rx_data, tx_ready,
    output tx_valid, tx_data
  );
endinterface

// File: rtl/uart_echo_fifo.sv
// First-word-fall-through FIFO between UART RX and TX, with overflow/drop statistics.
// Optional macro UART_ECHO_BYTESWAP_EN reverses byte-lane order on the read side.
module uart_echo_fifo #(
  parameter  int BITS_PER_WORD = 8,
  parameter  int W_OUT         = 16,
  parameter  int DEPTH         = 16,
  localparam int NUM_WORDS     = W_OUT / BITS_PER_WORD,
  localparam int ADDR_W        = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  uart_echo_fifo_if.slave     bus,
  input  logic                stat_clr,
  output logic [ADDR_W:0]     count,
  output logic                full,
  output logic                empty,
  output logic                overflow,
  output logic [7:0]          drop_count
);

  typedef logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0] lane_t;

  lane_t           mem [DEPTH];
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            push;
  logic            pop;
  logic            drop;
  lane_t           head;
  lane_t           out_lanes;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // The extra pointer MSB separates a full ring from an empty one.
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (ADDR_W + 1)'(DEPTH));
  assign empty = (count == '0);

  assign bus.tx_valid = !empty;
  assign pop          = bus.tx_valid && bus.tx_ready;
  assign push         = bus.rx_valid && (!full || pop);
  assign drop         = bus.rx_valid && full && !pop;

  assign head = mem[rd_ptr[ADDR_W-1:0]];

  always_comb begin
    out_lanes = head;
`ifdef UART_ECHO_BYTESWAP_EN
    for (int i = 0; i < NUM_WORDS; i++) begin
      out_lanes[i] = head[NUM_WORDS-1-i];
    end
`endif
  end

  assign bus.tx_data = out_lanes;

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr[ADDR_W-1:0]] <= bus.rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // A drop in the same cycle as a clear restarts the statistics at one drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else if (drop) begin
      overflow   <= 1'b1;
      drop_count <= stat_clr ? 8'd1 : sat_inc8(drop_count);
    end else if (stat_clr) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end
  end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Scoreboard bench for uart_echo_fifo: a queue model is updated from the driven inputs
// and every output is compared against it on each falling edge.
module tb_uart_echo_fifo;
  localparam int BPW   = 8;
  localparam int W     = 16;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       stat_clr;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic [7:0] drop_count;

  uart_echo_fifo_if #(.W_OUT(W)) bus ();

  uart_echo_fifo #(
    .BITS_PER_WORD(BPW),
    .W_OUT        (W),
    .DEPTH        (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .stat_clr  (stat_clr),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_out(input logic [W-1:0] w);
`ifdef UART_ECHO_BYTESWAP_EN
    return {w[7:0], w[15:8]};
`else
    return w;
`endif
  endfunction

  // Reference model state
  logic [W-1:0] q[$];
  bit           m_ov;
  int           m_dc;
  bit           model_ok = 1'b0;
  int           n_handshake = 0;

  always @(negedge clk) begin
    bit pop_m, push_m, drop_m;
    logic [W-1:0] dummy;
    if (model_ok) begin
      check("count", 32'(count), q.size());
      check("empty", 32'(empty), 32'(q.size() == 0));
      check("full", 32'(full), 32'(q.size() == DEPTH));
      check("tx_valid", 32'(bus.tx_valid), 32'(q.size() != 0));
      if (q.size() != 0) check("tx_data", 32'(bus.tx_data), 32'(exp_out(q[0])));
      check("overflow", 32'(overflow), 32'(m_ov));
      check("drop_count", 32'(drop_count), m_dc);
    end
    if (!rst && bus.tx_valid === 1'b1 && bus.tx_ready) n_handshake++;
    if (rst) begin
      q.delete();
      m_ov     = 1'b0;
      m_dc     = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      pop_m  = bus.tx_ready && (q.size() != 0);
      push_m = bus.rx_valid && ((q.size() < DEPTH) || pop_m);
      drop_m = bus.rx_valid && (q.size() == DEPTH) && !pop_m;
      if (pop_m) dummy = q.pop_front();
      if (push_m) q.push_back(bus.rx_data);
      if (drop_m) begin
        m_ov = 1'b1;
        m_dc = stat_clr ? 1 : ((m_dc == 255) ? 255 : m_dc + 1);
      end else if (stat_clr) begin
        m_ov = 1'b0;
        m_dc = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] d);
    bus.rx_data  = d;
    bus.rx_valid = 1'b1;
    step();
    bus.rx_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 200 && !empty; i++) step();
    @(negedge clk);
    check(tag, 32'(empty), 32'd1);
    step();
  endtask

  initial begin
    int pushed;
    rst          = 1'b1;
    stat_clr     = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    bus.tx_ready = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Idle after reset
    repeat (10) step();
    @(negedge clk);
    check("idle_count", 32'(count), 32'd0);
    check("idle_vld", 32'(bus.tx_valid), 32'd0);
    check("idle_dc", 32'(drop_count), 32'd0);
    step();

    // Single word, one-cycle latency
    bus.tx_ready = 1'b1;
    push_word(16'h1234);
    @(negedge clk);
    check("single_vld", 32'(bus.tx_valid), 32'd1);
    check("single_data", 32'(bus.tx_data), 32'(exp_out(16'h1234)));
    step();
    @(negedge clk);
    check("single_empty", 32'(empty), 32'd1);
    step();

    // Backpressure and ordering
    bus.tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push_word(W'(i));
    @(negedge clk);
    check("bp_count", 32'(count), 32'd5);
    step();
    repeat (3) step();
    drain("bp_drain");

    // Fill past full: two drops
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 18; i++) push_word(W'(16'h0100 + i));
    @(negedge clk);
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_dc", 32'(drop_count), 32'd2);
    step();

    // Push and pop together while full
    bus.tx_ready = 1'b1;
    push_word(16'hBEEF);
    bus.tx_ready = 1'b0;
    @(negedge clk);
    check("pp_count", 32'(count), 32'd16);
    check("pp_dc", 32'(drop_count), 32'd2);
    step();

    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    @(negedge clk);
    check("clr_ov", 32'(overflow), 32'd0);
    check("clr_dc", 32'(drop_count), 32'd0);
    step();

    // Saturation, then drop coinciding with clear
    for (int i = 0; i < 260; i++) push_word(W'(i));
    @(negedge clk);
    check("sat_dc", 32'(drop_count), 32'd255);
    step();
    stat_clr = 1'b1;
    push_word(16'h5555);
    stat_clr = 1'b0;
    @(negedge clk);
    check("dropclr_ov", 32'(overflow), 32'd1);
    check("dropclr_dc", 32'(drop_count), 32'd1);
    step();
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    drain("sat_drain");

    // 40-word stream with random gaps, across pointer wrap
    n_handshake = 0;
    pushed = 0;
    for (int g = 0; g < 2000 && pushed < 40; g++) begin
      bus.tx_ready = ($urandom_range(0, 3) != 0);
      bus.rx_valid = ($urandom_range(0, 1) == 1) && (q.size() < 12);
      bus.rx_data  = W'(16'hA000 + pushed);
      if (bus.rx_valid) pushed++;
      step();
    end
    bus.rx_valid = 1'b0;
    drain("wrap_drain");
    check("wrap_words", n_handshake, 40);

    // Reset mid-burst with a coincident rx_valid
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 7; i++) push_word(W'(16'h0700 + i));
    @(negedge clk);
    check("rst_pre_count", 32'(count), 32'd7);
    step();
    rst          = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 16'hDEAD;
    step();
    rst          = 1'b0;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_vld", 32'(bus.tx_valid), 32'd0);
    step();
    @(negedge clk);
    check("rst_nostore", 32'(empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
